// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: retirement record, entry layout,
// commit output and the completion-bus broadcast.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int PTR_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic        monitor_valid;
    logic [63:0] monitor_order;
    logic [31:0] monitor_inst;
    logic [4:0]  monitor_rs1_addr;
    logic [4:0]  monitor_rs2_addr;
    logic [4:0]  monitor_rd_addr;
    logic        monitor_regf_we;
    logic [31:0] monitor_rd_wdata;
    logic [31:0] monitor_pc_rdata;
    logic [31:0] monitor_pc_wdata;
  } rvfi_info;

  typedef struct packed {
    logic     valid;
    logic     commit;
    logic     mispredict;
    logic [5:0] pd;
    rvfi_info rvfi;
  } rob_entry_t;

  typedef struct packed {
    logic [5:0] phys_reg;
    logic [4:0] arch_reg;
  } rob_out_t;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] rob_idx;
    logic [31:0]      rd_v;
    logic             pc_select;
    logic [31:0]      pc_branch;
  } cdb_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retirement signals of the reorder buffer.
// master = rename/CDB/retire side, slave = the ROB itself.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             dispatch_valid;
  logic [5:0]       dispatch_pd;
  rvfi_info         dispatch_rvfi;
  logic             dispatch_ready;
  logic [PTR_W-1:0] dispatch_rob_idx;
  cdb_t             cdb;
  logic             commit_valid;
  rob_out_t         commit_out;
  rvfi_info         commit_rvfi;
  logic             flush;
  logic [31:0]      flush_pc;

  modport master (
    output dispatch_valid, dispatch_pd, dispatch_rvfi, cdb,
    input  dispatch_ready, dispatch_rob_idx, commit_valid, commit_out,
           commit_rvfi, flush, flush_pc
  );

  modport slave (
    input  dispatch_valid, dispatch_pd, dispatch_rvfi, cdb,
    output dispatch_ready, dispatch_rob_idx, commit_valid, commit_out,
           commit_rvfi, flush, flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail on dispatch, marks entries done
// from the CDB, retires one entry per cycle at head and flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);

  logic [PTR_W:0]       head_q, tail_q;
  logic [PTR_W-1:0]     head_idx, tail_idx;
  logic [ROB_DEPTH-1:0] valid_q, commit_q, misp_q;
  logic [5:0]           pd_q   [ROB_DEPTH];
  rvfi_info             rvfi_q [ROB_DEPTH];
  logic [63:0]          order_q;

  rob_entry_t head_e;
  rvfi_info   dispatch_e;
  logic       full;
  logic       commit_fire, flush_fire, dispatch_fire, cdb_fire;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign full     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);

  always_comb begin
    head_e.valid      = valid_q[head_idx];
    head_e.commit     = commit_q[head_idx];
    head_e.mispredict = misp_q[head_idx];
    head_e.pd         = pd_q[head_idx];
    head_e.rvfi       = rvfi_q[head_idx];
  end

  assign commit_fire   = head_e.valid & head_e.commit;
  assign flush_fire    = commit_fire & head_e.mispredict;
  // A flush squashes everything younger, including this cycle's dispatch and CDB write.
  assign dispatch_fire = rob.dispatch_valid & ~full & ~flush_fire;
  assign cdb_fire      = rob.cdb.valid & valid_q[rob.cdb.rob_idx] & ~flush_fire;

  always_comb begin
    dispatch_e                  = rob.dispatch_rvfi;
    dispatch_e.monitor_valid    = 1'b0;
    dispatch_e.monitor_order    = '0;
    dispatch_e.monitor_pc_wdata = rob.dispatch_rvfi.monitor_pc_rdata + 32'd4;
  end

  assign rob.dispatch_ready   = ~full;
  assign rob.dispatch_rob_idx = tail_idx;
  assign rob.commit_valid     = commit_fire;
  assign rob.flush            = flush_fire;

  // Retirement outputs are forced to zero whenever nothing retires.
  always_comb begin
    rob.commit_out  = '0;
    rob.commit_rvfi = '0;
    rob.flush_pc    = '0;
    if (commit_fire) begin
      rob.commit_out.phys_reg       = head_e.pd;
      rob.commit_out.arch_reg       = head_e.rvfi.monitor_rd_addr;
      rob.commit_rvfi               = head_e.rvfi;
      rob.commit_rvfi.monitor_valid = 1'b1;
      rob.commit_rvfi.monitor_order = order_q;
    end
    if (flush_fire) begin
      rob.flush_pc = head_e.rvfi.monitor_pc_wdata;
    end
  end

  // Entry payload: no reset, only read once the matching valid/commit bits say so.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      pd_q[tail_idx]   <= rob.dispatch_pd;
      rvfi_q[tail_idx] <= dispatch_e;
    end
    if (cdb_fire) begin
      rvfi_q[rob.cdb.rob_idx].monitor_rd_wdata <= rob.cdb.rd_v;
      if (rob.cdb.pc_select) begin
        rvfi_q[rob.cdb.rob_idx].monitor_pc_wdata <= rob.cdb.pc_branch;
      end
    end
  end

  // Pointers, per-entry status bits and the retirement order counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
      commit_q <= '0;
      misp_q   <= '0;
      order_q  <= '0;
    end else if (flush_fire) begin
      valid_q  <= '0;
      commit_q <= '0;
      misp_q   <= '0;
      head_q   <= head_q + (PTR_W+1)'(1);
      tail_q   <= head_q + (PTR_W+1)'(1);
      order_q  <= order_q + 64'd1;
    end else begin
      if (dispatch_fire) begin
        valid_q[tail_idx]  <= 1'b1;
        commit_q[tail_idx] <= 1'b0;
        misp_q[tail_idx]   <= 1'b0;
        tail_q             <= tail_q + (PTR_W+1)'(1);
      end
      if (cdb_fire) begin
        commit_q[rob.cdb.rob_idx] <= 1'b1;
        if (rob.cdb.pc_select) begin
          misp_q[rob.cdb.rob_idx] <= 1'b1;
        end
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + (PTR_W+1)'(1);
        order_q           <= order_q + 64'd1;
      end
    end
  end

endmodule
